axis_header_inserter: RTL and testbench



---
 rtl/axis_hdr_pkg.sv | 55 +++++
 rtl/axis_byte_merge.sv | 59 +++++
 rtl/axis_header_inserter.sv | 203 ++++++++++++++++++++
 tb/tb_axis_header_inserter.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_hdr_pkg.sv
// Shared types and byte-enable helpers for the AXI-Stream header inserter.
package axis_hdr_pkg;

  // Largest supported beat width in bytes; helpers work on this fixed width and
  // callers zero-extend their narrower keep vectors.
  localparam int unsigned MaxBytes = 64;
  localparam int unsigned MaxCntWd = 7;

  typedef logic [MaxBytes-1:0] keep_t;

  typedef enum logic [1:0] {
    StWaitHdr,
    StStream,
    StFlush
  } state_e;

  // Number of set enables.
  function automatic logic [MaxCntWd-1:0] popcount_keep(keep_t keep);
    logic [MaxCntWd-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < int'(MaxBytes); i++) begin
      cnt = cnt + MaxCntWd'(keep[i]);
    end
    return cnt;
  endfunction

  // n leading ones inside an nb-bit field (bit nb-1 is byte 0).
  function automatic keep_t keep_lead(logic [MaxCntWd-1:0] n, logic [MaxCntWd-1:0] nb);
    keep_t m;
    m = '0;
    for (int i = 0; i < int'(MaxBytes); i++) begin
      if ((i < int'(nb)) && (i >= int'(nb) - int'(n))) m[i] = 1'b1;
    end
    return m;
  endfunction

  // n trailing ones (low bits).
  function automatic keep_t keep_trail(logic [MaxCntWd-1:0] n);
    keep_t m;
    m = '0;
    for (int i = 0; i < int'(MaxBytes); i++) begin
      if (i < int'(n)) m[i] = 1'b1;
    end
    return m;
  endfunction

  // True when keep is a single contiguous run anchored at the expected end.
  function automatic logic is_contig(keep_t keep, logic [MaxCntWd-1:0] nb, logic left);
    logic [MaxCntWd-1:0] n;
    n = popcount_keep(keep);
    if (left) return keep == keep_lead(n, nb);
    return keep == keep_trail(n);
  endfunction

endpackage

// File: rtl/axis_byte_merge.sv
// Concatenates the pending residue with an incoming beat and splits the result
// into one output beat plus the bytes left over.
module axis_byte_merge
  import axis_hdr_pkg::*;
#(
  parameter int unsigned DataWd = 32,
  parameter int unsigned ByteWd = DataWd / 8,
  parameter int unsigned CntWd  = $clog2(ByteWd + 1)
) (
  input  logic [DataWd-1:0] residue_i,
  input  logic [CntWd-1:0]  r_i,
  input  logic [DataWd-1:0] beat_i,
  input  logic [CntWd-1:0]  k_i,
  output logic [DataWd-1:0] out_bytes_o,
  output logic [ByteWd-1:0] out_keep_o,
  output logic [DataWd-1:0] new_residue_o,
  output logic [CntWd-1:0]  new_r_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam int unsigned TotWd = CntWd + 1;

  logic [TotWd-1:0]    total;
  logic [DataWd-1:0]   res_mask;
  logic [DataWd-1:0]   beat_mask;
  logic [2*DataWd-1:0] joined;

  // Byte masks selecting the valid prefix of residue and beat.
  always_comb begin
    res_mask  = '0;
    beat_mask = '0;
    for (int i = 0; i < int'(ByteWd); i++) begin
      if (i < int'(r_i)) res_mask[DataWd-1-8*i -: 8] = 8'hff;
      if (i < int'(k_i)) beat_mask[DataWd-1-8*i -: 8] = 8'hff;
    end
  end

  // Residue bytes first, beat bytes appended right after them; unused bytes are 0.
  always_comb begin
    joined  = {residue_i & res_mask, {DataWd{1'b0}}} |
              ({beat_i & beat_mask, {DataWd{1'b0}}} >> {r_i, 3'b000});
    total   = TotWd'(r_i) + TotWd'(k_i);
    full_o  = (total >= TotWd'(ByteWd));
    empty_o = (total == '0);
    out_bytes_o = joined[2*DataWd-1 -: DataWd];
    if (full_o) begin
      out_keep_o    = '1;
      new_residue_o = joined[DataWd-1:0];
      new_r_o       = CntWd'(total - TotWd'(ByteWd));
    end else begin
      // Short result: the whole sequence fits in the leading bytes.
      out_keep_o    = ByteWd'(keep_lead(MaxCntWd'(total), MaxCntWd'(ByteWd)));
      new_residue_o = joined[2*DataWd-1 -: DataWd];
      new_r_o       = CntWd'(total);
    end
  end

endmodule

// File: rtl/axis_header_inserter.sv
// Prepends a 0..W byte header to each AXI-Stream packet, realigning payload
// bytes and emitting a trailing flush beat when bytes remain after the last beat.
module axis_header_inserter
  import axis_hdr_pkg::*;
#(
  parameter int unsigned DATA_WD      = 32,
  parameter int unsigned DATA_BYTE_WD = DATA_WD / 8,
  parameter int unsigned CNT_WD       = $clog2(DATA_BYTE_WD + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    valid_in,
  input  logic [DATA_WD-1:0]      data_in,
  input  logic [DATA_BYTE_WD-1:0] keep_in,
  input  logic                    last_in,
  output logic                    ready_in,
  output logic                    valid_out,
  output logic [DATA_WD-1:0]      data_out,
  output logic [DATA_BYTE_WD-1:0] keep_out,
  output logic                    last_out,
  input  logic                    ready_out,
  input  logic                    valid_insert,
  input  logic [DATA_WD-1:0]      header_insert,
  input  logic [DATA_BYTE_WD-1:0] keep_insert,
  output logic                    ready_insert,
  output logic                    err_keep
);

  localparam logic [MaxCntWd-1:0] NumBytes = MaxCntWd'(DATA_BYTE_WD);

  state_e                  state_q, state_d;
  logic [DATA_WD-1:0]      res_q, res_d;
  logic [CNT_WD-1:0]       r_q, r_d;
  logic                    vout_q, vout_d;
  logic [DATA_WD-1:0]      dout_q, dout_d;
  logic [DATA_BYTE_WD-1:0] kout_q, kout_d;
  logic                    lout_q, lout_d;
  logic                    err_q, err_d;

  logic                    slot_free;
  logic                    hdr_acc;
  logic                    beat_acc;
  logic [CNT_WD-1:0]       hdr_n;
  logic [CNT_WD-1:0]       beat_k;
  logic                    hdr_bad;
  logic                    beat_bad;

  logic                    load;
  logic                    ld_last;
  logic [DATA_WD-1:0]      ld_data;
  logic [DATA_BYTE_WD-1:0] ld_keep;

  logic [DATA_WD-1:0]      m_out;
  logic [DATA_BYTE_WD-1:0] m_keep;
  logic [DATA_WD-1:0]      m_res;
  logic [CNT_WD-1:0]       m_r;
  logic                    m_full;
  logic                    m_empty;

  // Handshakes; ready_in is the only path from ready_out that is not registered.
  assign slot_free    = !vout_q || ready_out;
  assign ready_insert = rst_n && (state_q == StWaitHdr);
  assign ready_in     = rst_n && (state_q == StStream) && slot_free;
  assign hdr_acc      = valid_insert && ready_insert;
  assign beat_acc     = valid_in && ready_in;

  // Byte counts always come from popcount, even when the enables are malformed.
  assign hdr_n    = CNT_WD'(popcount_keep(keep_t'(keep_insert)));
  assign beat_k   = CNT_WD'(popcount_keep(keep_t'(keep_in)));
  assign hdr_bad  = !is_contig(keep_t'(keep_insert), NumBytes, 1'b0);
  assign beat_bad = !is_contig(keep_t'(keep_in), NumBytes, 1'b1) ||
                    (!last_in && (keep_in != '1));

  axis_byte_merge #(
    .DataWd (DATA_WD),
    .ByteWd (DATA_BYTE_WD),
    .CntWd  (CNT_WD)
  ) u_merge (
    .residue_i     (res_q),
    .r_i           (r_q),
    .beat_i        (data_in),
    .k_i           (beat_k),
    .out_bytes_o   (m_out),
    .out_keep_o    (m_keep),
    .new_residue_o (m_res),
    .new_r_o       (m_r),
    .full_o        (m_full),
    .empty_o       (m_empty)
  );

  // Next-state, residue update and output-register load request.
  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    r_d     = r_q;
    load    = 1'b0;
    ld_last = 1'b0;
    ld_data = '0;
    ld_keep = '0;
    unique case (state_q)
      StWaitHdr: begin
        if (hdr_acc) begin
          // Low n header bytes moved to the front of the residue.
          res_d   = header_insert << (8 * (DATA_BYTE_WD - int'(hdr_n)));
          r_d     = hdr_n;
          state_d = StStream;
        end
      end
      StStream: begin
        if (beat_acc) begin
          if (m_full) begin
            load    = 1'b1;
            ld_data = m_out;
            ld_keep = m_keep;
            res_d   = m_res;
            r_d     = m_r;
            if (last_in) begin
              if (m_r != '0) begin
                state_d = StFlush;
              end else begin
                ld_last = 1'b1;
                state_d = StWaitHdr;
              end
            end
          end else if (last_in) begin
            res_d   = '0;
            r_d     = '0;
            state_d = StWaitHdr;
            if (!m_empty) begin
              load    = 1'b1;
              ld_data = m_out;
              ld_keep = m_keep;
              ld_last = 1'b1;
            end
          end else begin
            // Malformed short beat mid-packet: keep its bytes pending.
            res_d = m_res;
            r_d   = m_r;
          end
        end
      end
      StFlush: begin
        if (slot_free) begin
          load    = 1'b1;
          ld_data = res_q;
          ld_keep = DATA_BYTE_WD'(keep_lead(MaxCntWd'(r_q), NumBytes));
          ld_last = 1'b1;
          res_d   = '0;
          r_d     = '0;
          state_d = StWaitHdr;
        end
      end
      default: state_d = StWaitHdr;
    endcase
  end

  // Output register: reload when the slot frees up, otherwise hold.
  always_comb begin
    vout_d = vout_q;
    dout_d = dout_q;
    kout_d = kout_q;
    lout_d = lout_q;
    if (slot_free) begin
      vout_d = load;
      if (load) begin
        dout_d = ld_data;
        kout_d = ld_keep;
        lout_d = ld_last;
      end
    end
    err_d = (hdr_acc && hdr_bad) || (beat_acc && beat_bad);
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StWaitHdr;
      res_q   <= '0;
      r_q     <= '0;
      vout_q  <= 1'b0;
      dout_q  <= '0;
      kout_q  <= '0;
      lout_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      r_q     <= r_d;
      vout_q  <= vout_d;
      dout_q  <= dout_d;
      kout_q  <= kout_d;
      lout_q  <= lout_d;
      err_q   <= err_d;
    end
  end

  assign valid_out = vout_q;
  assign data_out  = dout_q;
  assign keep_out  = kout_q;
  assign last_out  = lout_q;
  assign err_keep  = err_q;

endmodule

// File: tb/tb_axis_header_inserter.sv
// Scoreboard bench for axis_header_inserter at DATA_WD=32.
module tb_axis_header_inserter;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_in;
  logic [31:0] data_in;
  logic [3:0]  keep_in;
  logic        last_in;
  logic        ready_in;
  logic        valid_out;
  logic [31:0] data_out;
  logic [3:0]  keep_out;
  logic        last_out;
  logic        ready_out;
  logic        valid_insert;
  logic [31:0] header_insert;
  logic [3:0]  keep_insert;
  logic        ready_insert;
  logic        err_keep;

  int    checks  = 0;
  int    fails   = 0;
  int    err_cnt = 0;
  beat_t exp_q[$];
  logic [7:0] pkt_bytes[$];
  logic  sink_hold = 1'b0;
  logic  sink_rand = 1'b0;
  logic  rand_gap  = 1'b0;

  axis_header_inserter #(
    .DATA_WD (32)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .valid_in      (valid_in),
    .data_in       (data_in),
    .keep_in       (keep_in),
    .last_in       (last_in),
    .ready_in      (ready_in),
    .valid_out     (valid_out),
    .data_out      (data_out),
    .keep_out      (keep_out),
    .last_out      (last_out),
    .ready_out     (ready_out),
    .valid_insert  (valid_insert),
    .header_insert (header_insert),
    .keep_insert   (keep_insert),
    .ready_insert  (ready_insert),
    .err_keep      (err_keep)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [31:0] d, input logic [3:0] k, input logic l);
    beat_t b;
    b.d = d;
    b.k = k;
    b.l = l;
    exp_q.push_back(b);
  endtask

  // Reference model: packet as a flat byte list, cut into 4-byte beats.
  task automatic model_hdr(input logic [31:0] h, input logic [3:0] k);
    int n;
    n = $countones(k);
    pkt_bytes.delete();
    for (int j = n - 1; j >= 0; j--) pkt_bytes.push_back(h[8*j +: 8]);
  endtask

  task automatic model_beat(input logic [31:0] d, input logic [3:0] k);
    int m;
    m = $countones(k);
    for (int i = 0; i < m; i++) pkt_bytes.push_back(d[31-8*i -: 8]);
  endtask

  task automatic model_close();
    while (pkt_bytes.size() > 0) begin
      beat_t b;
      b = '0;
      for (int i = 0; i < 4 && pkt_bytes.size() > 0; i++) begin
        b.d[31-8*i -: 8] = pkt_bytes.pop_front();
        b.k[3-i] = 1'b1;
      end
      b.l = (pkt_bytes.size() == 0);
      exp_q.push_back(b);
    end
  endtask

  // Drivers: called aligned to posedge+1, return aligned the same way.
  task automatic send_hdr(input logic [31:0] h, input logic [3:0] k);
    int cyc;
    cyc = 0;
    valid_insert  = 1'b1;
    header_insert = h;
    keep_insert   = k;
    do begin
      @(negedge clk);
      cyc++;
    end while (!ready_insert && cyc < 500);
    if (!ready_insert) begin
      checks++;
      fails++;
      $display("FAIL hdr_timeout: got no ready_insert, expected handshake");
    end
    sync();
    valid_insert = 1'b0;
  endtask

  task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
    int cyc;
    cyc = 0;
    while (rand_gap && $urandom_range(0, 3) == 0) sync();
    valid_in = 1'b1;
    data_in  = d;
    keep_in  = k;
    last_in  = l;
    do begin
      @(negedge clk);
      cyc++;
    end while (!ready_in && cyc < 500);
    if (!ready_in) begin
      checks++;
      fails++;
      $display("FAIL beat_timeout: got no ready_in, expected handshake");
    end
    sync();
    valid_in = 1'b0;
  endtask

  task automatic run_pkt(input logic [31:0] h, input logic [3:0] hk, input int nb,
                         input int klast);
    logic [31:0] d[$];
    logic [3:0]  k[$];
    logic [3:0]  kk;
    model_hdr(h, hk);
    for (int b = 0; b < nb; b++) begin
      kk = 4'hf;
      if (b == nb - 1) kk = kk << (4 - klast);
      d.push_back($urandom);
      k.push_back(kk);
      model_beat(d[b], kk);
    end
    model_close();
    send_hdr(h, hk);
    for (int b = 0; b < nb; b++) send_beat(d[b], k[b], b == nb - 1);
  endtask

  task automatic wait_drain();
    int cyc;
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    chk("drain_pending", 64'(exp_q.size()), 0);
    sync();
  endtask

  // Downstream ready generator.
  initial begin
    ready_out = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (sink_hold) ready_out = 1'b0;
      else if (sink_rand) ready_out = ($urandom_range(0, 3) != 0);
      else ready_out = 1'b1;
    end
  end

  // Monitor: pops expectations on every transfer, checks stall stability.
  initial begin
    logic        pv, pr, prst, pl;
    logic [31:0] pd;
    logic [3:0]  pk;
    beat_t       e;
    pv = 1'b0; pr = 1'b0; prst = 1'b0; pl = 1'b0; pd = '0; pk = '0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (err_keep) err_cnt++;
        if (prst && pv && !pr) begin
          chk("stall_hold", {valid_out, data_out, keep_out, last_out}, {1'b1, pd, pk, pl});
        end
        if (valid_out && !ready_out) chk("stall_ready_in", 64'(ready_in), 0);
        if (valid_out && ready_out) begin
          if (exp_q.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL extra_beat: got %h/%b/%b, expected none", data_out, keep_out,
                     last_out);
          end else begin
            e = exp_q.pop_front();
            chk("beat", {data_out, keep_out, last_out}, {e.d, e.k, e.l});
          end
        end
      end
      pv = valid_out; pr = ready_out; prst = rst_n;
      pd = data_out; pk = keep_out; pl = last_out;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n;
    logic [3:0]  hk;
    rst_n = 1'b0;
    valid_in = 1'b0; data_in = '0; keep_in = '0; last_in = 1'b0;
    valid_insert = 1'b0; header_insert = '0; keep_insert = '0;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_outputs", {valid_out, data_out, keep_out, last_out, err_keep},
        {1'b0, 32'h0, 4'h0, 1'b0, 1'b0});
    chk("rst_ready_in", 64'(ready_in), 0);
    chk("rst_ready_insert", 64'(ready_insert), 0);
    sync();
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready_insert", 64'(ready_insert), 1);
    sync();

    // 2-byte header, two full beats
    push_exp(32'h11220102, 4'b1111, 1'b0);
    push_exp(32'h03040506, 4'b1111, 1'b0);
    push_exp(32'h07080000, 4'b1100, 1'b1);
    send_hdr(32'h00001122, 4'b0011);
    send_beat(32'h01020304, 4'b1111, 1'b0);
    send_beat(32'h05060708, 4'b1111, 1'b1);

    // Empty header: pass-through, no flush
    push_exp(32'hdeadbe00, 4'b1110, 1'b1);
    send_hdr(32'h12345678, 4'b0000);
    send_beat(32'hdeadbeef, 4'b1110, 1'b1);

    // Full header: always a flush beat
    push_exp(32'hcafef00d, 4'b1111, 1'b0);
    push_exp(32'h01000000, 4'b1000, 1'b1);
    send_hdr(32'hcafef00d, 4'b1111);
    send_beat(32'h01020304, 4'b1000, 1'b1);

    // 3-byte header, partial single beat
    push_exp(32'habcdef11, 4'b1111, 1'b0);
    push_exp(32'h22000000, 4'b1000, 1'b1);
    send_hdr(32'h00abcdef, 4'b0111);
    send_beat(32'h11223344, 4'b1100, 1'b1);
    wait_drain();

    // Downstream stall mid-packet, then a back-to-back packet
    fork
      run_pkt(32'h0000a55a, 4'b0011, 5, 4);
      begin
        repeat (4) @(negedge clk);
        sink_hold = 1'b1;
        repeat (5) @(negedge clk);
        sink_hold = 1'b0;
      end
    join
    run_pkt(32'h00778899, 4'b0111, 3, 2);
    wait_drain();

    // Non-contiguous header enables: error pulse, popcount bytes used
    push_exp(32'haabb0102, 4'b1111, 1'b0);
    push_exp(32'h03040000, 4'b1100, 1'b1);
    send_hdr(32'h0000aabb, 4'b0101);
    send_beat(32'h01020304, 4'b1111, 1'b1);
    wait_drain();
    chk("err_pulse_once", 64'(err_cnt), 1);

    // Reset while in FLUSH with the output stalled
    @(negedge clk);
    sink_hold = 1'b1;
    sync();
    send_hdr(32'hcafef00d, 4'b1111);
    send_beat(32'h01020304, 4'b1000, 1'b1);
    @(negedge clk);
    chk("flush_stalled_valid", 64'(valid_out), 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_out", {valid_out, last_out}, {1'b0, 1'b0});
    chk("mid_rst_ready", {ready_in, ready_insert}, {1'b0, 1'b0});
    rst_n = 1'b1;
    sink_hold = 1'b0;
    @(negedge clk);
    chk("after_rst_ready_insert", 64'(ready_insert), 1);
    sync();
    push_exp(32'h11220102, 4'b1111, 1'b0);
    push_exp(32'h03040506, 4'b1111, 1'b0);
    push_exp(32'h07080000, 4'b1100, 1'b1);
    send_hdr(32'h00001122, 4'b0011);
    send_beat(32'h01020304, 4'b1111, 1'b0);
    send_beat(32'h05060708, 4'b1111, 1'b1);
    wait_drain();

    // Randomised packets with random gaps and backpressure
    sink_rand = 1'b1;
    rand_gap  = 1'b1;
    for (int p = 0; p < 60; p++) begin
      n  = $urandom_range(0, 4);
      hk = 4'((1 << n) - 1);
      run_pkt($urandom, hk, $urandom_range(1, 5), $urandom_range(0, 4));
    end
    wait_drain();
    sink_rand = 1'b0;
    repeat (5) sync();
    chk("err_total", 64'(err_cnt), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
